axil_region_if: RTL and testbench

Parametrised AXI4-Lite slave front end for the replica accelerator register space. Next generation of the single-FSM bus interface: independent write and read channels, a configurable number of address-decoded target regions, byte strobes forwarded to targets, per-region read wait-states, and error responses for unmapped addresses and stalled reads. Sits between the PS AXI-Lite port and the replica control, ordering, distance and seed targets.

---
 rtl/axil_region_pkg.sv | 31 +++
 rtl/axil_region_dec.sv | 32 +++
 rtl/axil_region_if.sv | 248 ++++++++++++++++++++++++
 tb/tb_axil_region_if.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_region_pkg.sv
// Shared types and helpers for the AXI4-Lite region front end.
//   wr_state_t / rd_state_t : write and read channel FSM states
//   RESP_*                  : AXI response codes
//   region_hit()            : masked selector compare for one region
package axil_region_pkg;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Operands are zero-extended to 32 bits so any selector width up to 32 fits.
  function automatic logic region_hit(input logic [31:0] sel,
                                      input logic [31:0] id,
                                      input logic [31:0] mask);
    return (sel & mask) == id;
  endfunction

endpackage

// File: rtl/axil_region_dec.sv
// Combinational region decoder.
//   sel    in  SEL_W       region selector field of an address
//   hit_oh out REGION_NUM  one-hot hit, lowest region index wins on overlap
//   miss   out 1           no region matched
module axil_region_dec
  import axil_region_pkg::*;
#(
  parameter int                          REGION_NUM  = 4,
  parameter int                          SEL_W       = 8,
  parameter logic [REGION_NUM*SEL_W-1:0] REGION_ID   = {8'h00, 8'h01, 8'h02, 8'h08},
  parameter logic [REGION_NUM*SEL_W-1:0] REGION_MASK = {8'hff, 8'hff, 8'hff, 8'hf8}
) (
  input  logic [SEL_W-1:0]      sel,
  output logic [REGION_NUM-1:0] hit_oh,
  output logic                  miss
);

  // Region 0 is the leftmost entry of the ID/MASK concatenations.
  always_comb begin
    hit_oh = '0;
    miss   = 1'b1;
    for (int r = 0; r < REGION_NUM; r++) begin
      if (miss && region_hit(32'(sel),
                             32'(REGION_ID[(REGION_NUM-1-r)*SEL_W +: SEL_W]),
                             32'(REGION_MASK[(REGION_NUM-1-r)*SEL_W +: SEL_W]))) begin
        hit_oh[r] = 1'b1;
        miss      = 1'b0;
      end
    end
  end

endmodule

// File: rtl/axil_region_if.sv
// AXI4-Lite slave front end with address-decoded target regions.
//   S_AXI_ACLK / S_AXI_ARESETN : clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*            : AXI4-Lite write channels
//   S_AXI_AR*/R*               : AXI4-Lite read channels
//   wr_valid/wr_addr/wr_data/wr_strb : one-cycle write pulse to one region
//   rd_req/rd_addr             : one-cycle read request to one region
//   rd_ready/rd_data           : per-region read completion and data
module axil_region_if
  import axil_region_pkg::*;
#(
  parameter int                          DATA_W      = 64,
  parameter int                          ADDR_W      = 32,
  parameter int                          REGION_NUM  = 4,
  parameter int                          SEL_LSB     = 12,
  parameter int                          SEL_W       = 8,
  parameter logic [REGION_NUM*SEL_W-1:0] REGION_ID   = {8'h00, 8'h01, 8'h02, 8'h08},
  parameter logic [REGION_NUM*SEL_W-1:0] REGION_MASK = {8'hff, 8'hff, 8'hff, 8'hf8},
  parameter int                          RD_TIMEOUT  = 255
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESETN,
  input  logic [ADDR_W-1:0]            S_AXI_AWADDR,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [DATA_W-1:0]            S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]          S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic [ADDR_W-1:0]            S_AXI_ARADDR,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [DATA_W-1:0]            S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  output logic [REGION_NUM-1:0]        wr_valid,
  output logic [SEL_LSB-1:0]           wr_addr,
  output logic [DATA_W-1:0]            wr_data,
  output logic [DATA_W/8-1:0]          wr_strb,
  output logic [REGION_NUM-1:0]        rd_req,
  output logic [SEL_LSB-1:0]           rd_addr,
  input  logic [REGION_NUM-1:0]        rd_ready,
  input  logic [REGION_NUM*DATA_W-1:0] rd_data
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB_W  = $clog2(STRB_W);

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                  awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [REGION_NUM-1:0] aw_oh, ar_oh, aw_oh_q, rd_sel_q, wr_valid_q, rd_req_q;
  logic                  aw_miss, ar_miss, aw_miss_q;
  logic [SEL_LSB-1:0]    wr_addr_q, rd_addr_q, aw_off, ar_off;
  logic [DATA_W-1:0]     wr_data_q, rd_mux, rdata_d;
  logic [STRB_W-1:0]     wr_strb_q, strb_n;
  logic [REGION_NUM-1:0] aw_oh_n;
  logic                  aw_miss_n, enter_wresp, r_load, rd_sel_ready;
  logic [1:0]            rresp_d;
  logic [7:0]            rd_cnt_q;
  logic                  aw_hs, w_hs, ar_hs;

  // Only the selector field and the word offset carry meaning.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR};

  axil_region_dec #(
    .REGION_NUM(REGION_NUM), .SEL_W(SEL_W),
    .REGION_ID(REGION_ID), .REGION_MASK(REGION_MASK)
  ) u_aw_dec (
    .sel(S_AXI_AWADDR[SEL_LSB +: SEL_W]), .hit_oh(aw_oh), .miss(aw_miss)
  );

  axil_region_dec #(
    .REGION_NUM(REGION_NUM), .SEL_W(SEL_W),
    .REGION_ID(REGION_ID), .REGION_MASK(REGION_MASK)
  ) u_ar_dec (
    .sel(S_AXI_ARADDR[SEL_LSB +: SEL_W]), .hit_oh(ar_oh), .miss(ar_miss)
  );

  assign aw_off = {S_AXI_AWADDR[SEL_LSB-1:LSB_W], {LSB_W{1'b0}}};
  assign ar_off = {S_AXI_ARADDR[SEL_LSB-1:LSB_W], {LSB_W{1'b0}}};

  // Readies are registered copies of the state, so they are low in reset.
  assign aw_hs = S_AXI_AWVALID && awready_q;
  assign w_hs  = S_AXI_WVALID  && wready_q;
  assign ar_hs = S_AXI_ARVALID && arready_q;

  // ---- write channel: state decode ----
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE: begin
        if (aw_hs && w_hs) wr_next = W_RESP;
        else if (aw_hs)    wr_next = W_HAVE_A;
        else if (w_hs)     wr_next = W_HAVE_D;
      end
      W_HAVE_A: if (w_hs)  wr_next = W_RESP;
      W_HAVE_D: if (aw_hs) wr_next = W_RESP;
      W_RESP:   if (S_AXI_BREADY) wr_next = W_IDLE;
      default:  wr_next = W_IDLE;
    endcase
  end

  // Values as they will stand in the first W_RESP cycle, which may be the
  // same edge that captures AW and/or W.
  assign aw_oh_n     = aw_hs ? aw_oh   : aw_oh_q;
  assign aw_miss_n   = aw_hs ? aw_miss : aw_miss_q;
  assign strb_n      = w_hs  ? S_AXI_WSTRB : wr_strb_q;
  assign enter_wresp = (wr_next == W_RESP) && (wr_state != W_RESP);

  // ---- write channel: registers ----
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) wr_state <= W_IDLE;
    else                wr_state <= wr_next;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_valid_q <= '0;
      aw_oh_q    <= '0;
      aw_miss_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
    end else begin
      awready_q  <= (wr_next == W_IDLE) || (wr_next == W_HAVE_D);
      wready_q   <= (wr_next == W_IDLE) || (wr_next == W_HAVE_A);
      bvalid_q   <= (wr_next == W_RESP);
      wr_valid_q <= (enter_wresp && (|strb_n)) ? aw_oh_n : '0;
      if (enter_wresp) bresp_q <= aw_miss_n ? RESP_DECERR : RESP_OKAY;
      if (aw_hs) begin
        aw_oh_q   <= aw_oh;
        aw_miss_q <= aw_miss;
        wr_addr_q <= aw_off;
      end
      if (w_hs) begin
        wr_data_q <= S_AXI_WDATA;
        wr_strb_q <= S_AXI_WSTRB;
      end
    end
  end

  // ---- read channel: target select and state decode ----
  // Region r drives rd_data[r*DATA_W +: DATA_W].
  always_comb begin
    rd_mux = '0;
    for (int r = 0; r < REGION_NUM; r++) begin
      if (rd_sel_q[r]) rd_mux = rd_mux | rd_data[r*DATA_W +: DATA_W];
    end
  end

  assign rd_sel_ready = |(rd_ready & rd_sel_q);

  always_comb begin
    rd_next = rd_state;
    rdata_d = '0;
    rresp_d = RESP_OKAY;
    r_load  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (ar_hs) begin
          if (ar_miss) begin
            rd_next = R_RESP;
            rresp_d = RESP_DECERR;
            r_load  = 1'b1;
          end else begin
            rd_next = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        // A target answering on the timeout cycle still wins.
        if (rd_sel_ready) begin
          rd_next = R_RESP;
          rdata_d = rd_mux;
          r_load  = 1'b1;
        end else if (rd_cnt_q == 8'(RD_TIMEOUT)) begin
          rd_next = R_RESP;
          rresp_d = RESP_SLVERR;
          r_load  = 1'b1;
        end
      end
      R_RESP:  if (S_AXI_RREADY) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // ---- read channel: registers ----
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) rd_state <= R_IDLE;
    else                rd_state <= rd_next;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rd_req_q  <= '0;
      rd_sel_q  <= '0;
      rd_addr_q <= '0;
      rd_cnt_q  <= '0;
    end else begin
      arready_q <= (rd_next == R_IDLE);
      rvalid_q  <= (rd_next == R_RESP);
      rd_req_q  <= '0;
      if (ar_hs) begin
        rd_sel_q  <= ar_oh;
        rd_addr_q <= ar_off;
        rd_req_q  <= ar_oh;   // all-zero on a miss
      end
      // Counts wait cycles: 0 in the rd_req cycle.
      rd_cnt_q <= (rd_state == R_WAIT) ? rd_cnt_q + 8'd1 : 8'd0;
      if (r_load) begin
        rdata_q <= rdata_d;
        rresp_q <= rresp_d;
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign wr_valid      = wr_valid_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign wr_strb       = wr_strb_q;
  assign rd_req        = rd_req_q;
  assign rd_addr       = rd_addr_q;

endmodule

// File: tb/tb_axil_region_if.sv
module tb_axil_region_if;

  localparam int RD_TIMEOUT = 255;

  logic         clk = 1'b0;
  logic         S_AXI_ARESETN;
  logic [31:0]  S_AXI_AWADDR, S_AXI_ARADDR;
  logic         S_AXI_AWVALID, S_AXI_AWREADY;
  logic [63:0]  S_AXI_WDATA, S_AXI_RDATA;
  logic [7:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP, S_AXI_RRESP;
  logic         S_AXI_BVALID, S_AXI_BREADY;
  logic         S_AXI_ARVALID, S_AXI_ARREADY;
  logic         S_AXI_RVALID, S_AXI_RREADY;
  logic [3:0]   wr_valid, rd_req, rd_ready_tb;
  logic [11:0]  wr_addr, rd_addr;
  logic [63:0]  wr_data;
  logic [7:0]   wr_strb;
  logic [255:0] rd_data_tb;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; logic [3:0] oh; logic [11:0] addr; logic [63:0] data; logic [7:0] strb; } wexp_t;
  typedef struct { int cyc; logic [1:0] resp; } bexp_t;
  typedef struct { int cyc; logic [63:0] data; logic [1:0] resp; } rexp_t;
  typedef struct { int cyc; logic [3:0] oh; logic [11:0] addr; } qexp_t;

  wexp_t wq[$];
  bexp_t bq[$];
  rexp_t rdq[$];
  qexp_t rqq[$];

  axil_region_if dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(S_AXI_ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready_tb), .rd_data(rd_data_tb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected nothing (cycle %0d)", name, act, cyc);
  endtask

  function automatic logic [11:0] off(input logic [31:0] a);
    return {a[11:3], 3'b000};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
                              S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RRESP, wr_valid, rd_req}), 64'd0);
    chk({tag, "_rdata"}, S_AXI_RDATA, 64'd0);
    chk({tag, "_wdata"}, wr_data, 64'd0);
    chk({tag, "_addr"}, 64'({wr_addr, rd_addr, wr_strb}), 64'd0);
  endtask

  // Release in one cycle; readies must stay low there and rise in the next.
  task automatic release_and_check();
    @(posedge clk); #1;
    S_AXI_ARESETN = 1'b1;
    @(negedge clk);
    chk("ready_at_release", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'd0);
    @(negedge clk);
    chk("ready_after_release", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'h7);
    @(posedge clk); #1;
  endtask

  task automatic aw_send(input logic [31:0] a, output int hs);
    S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1; hs = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (S_AXI_AWREADY) begin hs = cyc; break; end
    end
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0;
    if (hs < 0) flag_fail("aw_handshake_timeout", 64'(a));
  endtask

  task automatic w_send(input logic [63:0] d, input logic [7:0] s, output int hs);
    S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1; hs = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (S_AXI_WREADY) begin hs = cyc; break; end
    end
    @(posedge clk); #1;
    S_AXI_WVALID = 1'b0;
    if (hs < 0) flag_fail("w_handshake_timeout", d);
  endtask

  task automatic ar_send(input logic [31:0] a, output int hs);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; hs = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (S_AXI_ARREADY) begin hs = cyc; break; end
    end
    @(posedge clk); #1;
    S_AXI_ARVALID = 1'b0;
    if (hs < 0) flag_fail("ar_handshake_timeout", 64'(a));
  endtask

  task automatic wr_txn(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                        input int aw_dly, input int w_dly,
                        input logic [3:0] exp_oh, input logic [1:0] exp_resp);
    int ha, hw, m;
    fork
      begin repeat (aw_dly) begin @(posedge clk); #1; end aw_send(a, ha); end
      begin repeat (w_dly) begin @(posedge clk); #1; end w_send(d, s, hw); end
    join
    m = (ha > hw) ? ha : hw;
    if (exp_oh != 4'd0 && s != 8'd0) wq.push_back('{m + 1, exp_oh, off(a), d, s});
    bq.push_back('{m + 1, exp_resp});
  endtask

  // region < 0: unmapped; k < 0: target never answers.
  task automatic rd_txn(input logic [31:0] a, input int region, input int k,
                        input logic [63:0] exp_d, input logic [1:0] exp_resp);
    int n;
    ar_send(a, n);
    if (region < 0) begin
      rdq.push_back('{n + 1, 64'd0, exp_resp});
    end else begin
      rqq.push_back('{n + 1, 4'(1 << region), off(a)});
      rdq.push_back('{(k < 0) ? n + 2 + RD_TIMEOUT : n + 2 + k, exp_d, exp_resp});
      if (k >= 0) begin
        repeat (k) begin @(posedge clk); #1; end
        rd_ready_tb[region] = 1'b1;
        @(posedge clk); #1;
        rd_ready_tb[region] = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wq.size() == 0 && bq.size() == 0 && rdq.size() == 0 && rqq.size() == 0 &&
          !S_AXI_BVALID && !S_AXI_RVALID) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (!ok) flag_fail("idle_timeout", 64'(bq.size() + rdq.size()));
  endtask

  // Monitor: compares every DUT output event against the scoreboard queues.
  bit b_seen = 1'b0, r_seen = 1'b0;
  logic [1:0]  b_hold, r_hold_resp;
  logic [63:0] r_hold_data;
  wexp_t we; bexp_t be; rexp_t re; qexp_t qe;

  initial forever begin
    @(negedge clk);
    if (!S_AXI_ARESETN) begin
      b_seen = 1'b0; r_seen = 1'b0;
    end else begin
      if (wr_valid != 4'd0) begin
        if (wq.size() == 0) flag_fail("wr_valid_unexpected", 64'(wr_valid));
        else begin
          we = wq.pop_front();
          chk("wr_cycle", 64'(cyc), 64'(we.cyc));
          chk("wr_valid", 64'(wr_valid), 64'(we.oh));
          chk("wr_addr", 64'(wr_addr), 64'(we.addr));
          chk("wr_data", wr_data, we.data);
          chk("wr_strb", 64'(wr_strb), 64'(we.strb));
        end
      end
      if (rd_req != 4'd0) begin
        if (rqq.size() == 0) flag_fail("rd_req_unexpected", 64'(rd_req));
        else begin
          qe = rqq.pop_front();
          chk("rd_req_cycle", 64'(cyc), 64'(qe.cyc));
          chk("rd_req", 64'(rd_req), 64'(qe.oh));
          chk("rd_addr", 64'(rd_addr), 64'(qe.addr));
        end
      end
      if (S_AXI_BVALID) begin
        if (!b_seen) begin
          if (bq.size() == 0) flag_fail("b_unexpected", 64'(S_AXI_BRESP));
          else begin
            be = bq.pop_front();
            chk("b_cycle", 64'(cyc), 64'(be.cyc));
            chk("bresp", 64'(S_AXI_BRESP), 64'(be.resp));
          end
          b_seen = 1'b1; b_hold = S_AXI_BRESP;
        end else begin
          chk("bresp_hold", 64'(S_AXI_BRESP), 64'(b_hold));
        end
        if (S_AXI_BREADY) b_seen = 1'b0;
      end else if (b_seen) begin
        flag_fail("bvalid_dropped", 64'd0);
        b_seen = 1'b0;
      end
      if (S_AXI_RVALID) begin
        if (!r_seen) begin
          if (rdq.size() == 0) flag_fail("r_unexpected", S_AXI_RDATA);
          else begin
            re = rdq.pop_front();
            chk("r_cycle", 64'(cyc), 64'(re.cyc));
            chk("rdata", S_AXI_RDATA, re.data);
            chk("rresp", 64'(S_AXI_RRESP), 64'(re.resp));
          end
          r_seen = 1'b1; r_hold_data = S_AXI_RDATA; r_hold_resp = S_AXI_RRESP;
        end else begin
          chk("rdata_hold", S_AXI_RDATA, r_hold_data);
          chk("rresp_hold", 64'(S_AXI_RRESP), 64'(r_hold_resp));
        end
        if (S_AXI_RREADY) r_seen = 1'b0;
      end else if (r_seen) begin
        flag_fail("rvalid_dropped", 64'd0);
        r_seen = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    S_AXI_ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
    rd_ready_tb = '0;
    rd_data_tb = {64'hD3D3_D3D3_D3D3_D3D3, 64'h0000_0000_0000_1234,
                  64'hB1B1_0000_0000_00B1, 64'hA0A0_0000_0000_00A0};

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    release_and_check();

    // Simultaneous AW+W to region 1.
    wr_txn(32'h0000_1010, 64'hDEAD_BEEF_0000_0001, 8'hFF, 0, 0, 4'b0010, 2'b00);
    wait_idle(50);

    // AW first, W three cycles later, BREADY held low for four response cycles.
    S_AXI_BREADY = 1'b0;
    wr_txn(32'h0000_2018, 64'h0123_4567_89AB_CDEF, 8'h0F, 0, 3, 4'b0100, 2'b00);
    repeat (4) begin @(posedge clk); #1; end
    chk("bvalid_held", 64'(S_AXI_BVALID), 64'd1);
    S_AXI_BREADY = 1'b1;
    wait_idle(50);

    // Zero strobes: OKAY response, no write pulse.
    wr_txn(32'h0000_2000, 64'h0000_0000_0000_FFFF, 8'h00, 0, 0, 4'b0100, 2'b00);
    wait_idle(50);

    // Region 2 read, target answers five cycles after rd_req; RREADY stalls.
    S_AXI_RREADY = 1'b0;
    rd_txn(32'h0000_2008, 2, 5, 64'h0000_0000_0000_1234, 2'b00);
    repeat (3) begin @(posedge clk); #1; end
    S_AXI_RREADY = 1'b1;
    wait_idle(50);

    // Unmapped read and write.
    rd_txn(32'h0004_0000, -1, 0, 64'd0, 2'b11);
    wait_idle(50);
    wr_txn(32'h0004_0000, 64'h1111_2222_3333_4444, 8'hFF, 0, 0, 4'b0000, 2'b11);
    wait_idle(50);

    // Region 3 (masked selector 0x0F) never answers; a region 0 write runs meanwhile.
    fork
      rd_txn(32'h0000_F010, 3, -1, 64'd0, 2'b10);
      begin
        repeat (20) begin @(posedge clk); #1; end
        wr_txn(32'h0000_0028, 64'h0000_0000_CAFE_F00D, 8'h3C, 0, 0, 4'b0001, 2'b00);
      end
    join
    wait_idle(400);

    // Reset with the read in R_WAIT and the write in W_HAVE_A.
    ar_send(32'h0000_9000, n);
    rqq.push_back('{n + 1, 4'b1000, 12'h000});
    aw_send(32'h0000_0040, n);
    repeat (3) begin @(posedge clk); #1; end
    S_AXI_ARESETN = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    release_and_check();

    // Fresh traffic after reset; low address bits must be ignored.
    wr_txn(32'h0000_1037, 64'h5555_AAAA_0000_FFFF, 8'hF0, 0, 0, 4'b0010, 2'b00);
    wait_idle(50);
    rd_txn(32'h0000_100C, 1, 0, 64'hB1B1_0000_0000_00B1, 2'b00);
    wait_idle(50);

    repeat (5) @(posedge clk);
    chk("queues_drained", 64'(wq.size() + bq.size() + rdq.size() + rqq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
